cpu: RTL and testbench

- Hardwired control unit for the TEC-8 style 8-bit teaching computer.
- Decodes the console switches (swc, swb, swa), opcode ir[7:4], beat signals w1/w2/w3 and flags c/z into datapath micro-controls: ALU, bus gates, register select, memory, PC/AR and sequencer length.
- Sits between the external beat generator/switch panel and the datapath.
- Only internal state is the 1-bit phase flag st0.

---
 rtl/cpu_if.sv | 37 +++
 rtl/cpu.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_if.sv
// Signal bundle between the TEC-8 panel/sequencer/datapath and the
// hardwired control unit.
interface cpu_if;
    logic       swa, swb, swc;
    logic [7:4] ir;
    logic       w1, w2, w3;
    logic       c, z;
    logic       drw, pcinc, lpc, lar;
    logic       pcadd, arinc, selctl, memw;
    logic       stop, lir, ldz, ldc, cin;
    logic [3:0] s;
    logic       m, abus, sbus, mbus;
    logic       short_cyc, long_cyc;
    logic       sel0, sel1, sel2, sel3;

    modport master (
        output swa, swb, swc, ir,
        output w1, w2, w3, c, z,
        input  drw, pcinc, lpc, lar,
        input  pcadd, arinc, selctl, memw,
        input  stop, lir, ldz, ldc, cin,
        input  s, m, abus, sbus, mbus,
        input  short_cyc, long_cyc,
        input  sel0, sel1, sel2, sel3
    );

    modport slave (
        input  swa, swb, swc, ir,
        input  w1, w2, w3, c, z,
        output drw, pcinc, lpc, lar,
        output pcadd, arinc, selctl, memw,
        output stop, lir, ldz, ldc, cin,
        output s, m, abus, sbus, mbus,
        output short_cyc, long_cyc,
        output sel0, sel1, sel2, sel3
    );
endinterface

// File: rtl/cpu.sv
// TEC-8 hardwired control unit: console modes plus run-mode
// instruction decode, with a single phase flag st0.
module cpu (
    input logic   t3,
    input logic   clr,
    cpu_if.slave  b
);
    logic       st0;
    logic       set_st0;
    logic [2:0] mode;

    assign mode = {b.swc, b.swb, b.swa};

    always_ff @(negedge t3 or posedge clr) begin
        if (clr)
            st0 <= 1'b0;
        else if (set_st0)
            st0 <= 1'b1;
    end

    always_comb begin
        b.drw       = 1'b0;
        b.pcinc     = 1'b0;
        b.lpc       = 1'b0;
        b.lar       = 1'b0;
        b.pcadd     = 1'b0;
        b.arinc     = 1'b0;
        b.selctl    = 1'b0;
        b.memw      = 1'b0;
        b.stop      = 1'b0;
        b.lir       = 1'b0;
        b.ldz       = 1'b0;
        b.ldc       = 1'b0;
        b.cin       = 1'b0;
        b.s         = 4'b0000;
        b.m         = 1'b0;
        b.abus      = 1'b0;
        b.sbus      = 1'b0;
        b.mbus      = 1'b0;
        b.short_cyc = 1'b0;
        b.long_cyc  = 1'b0;
        b.sel0      = 1'b0;
        b.sel1      = 1'b0;
        b.sel2      = 1'b0;
        b.sel3      = 1'b0;
        set_st0     = 1'b0;

        if (!clr) begin
            unique case (mode)
                3'b001, 3'b010: begin
                    if (b.w1) begin
                        b.stop      = 1'b1;
                        b.short_cyc = 1'b1;
                        b.selctl    = 1'b1;
                        if (!st0) begin
                            b.sbus  = 1'b1;
                            b.lar   = 1'b1;
                            set_st0 = 1'b1;
                        end else if (mode == 3'b001) begin
                            b.sbus  = 1'b1;
                            b.memw  = 1'b1;
                            b.arinc = 1'b1;
                        end else begin
                            b.mbus  = 1'b1;
                            b.arinc = 1'b1;
                        end
                    end
                end

                3'b011: begin
                    if (b.w1 | b.w2) begin
                        b.selctl = 1'b1;
                        b.stop   = 1'b1;
                        b.sel0   = 1'b1;
                    end
                    if (b.w2) begin
                        b.sel3 = 1'b1;
                        b.sel1 = 1'b1;
                    end
                end

                3'b100: begin
                    if (b.w1 | b.w2) begin
                        b.sbus   = 1'b1;
                        b.drw    = 1'b1;
                        b.selctl = 1'b1;
                        b.stop   = 1'b1;
                        b.sel3   = st0;
                    end
                    b.sel2  = b.w2;
                    b.sel1  = (!st0 & b.w1) | (st0 & b.w2);
                    b.sel0  = b.w1;
                    set_st0 = b.w2 & !st0;
                end

                3'b000: begin
                    if (!st0) begin
                        if (b.w1) begin
                            b.sbus = 1'b1;
                            b.lpc  = 1'b1;
                        end
                        if (b.w2) begin
                            b.lir   = 1'b1;
                            b.pcinc = 1'b1;
                            set_st0 = 1'b1;
                        end
                    end else begin
                        // Fetch of the next opcode rides on the last beat
                        case (b.ir)
                            4'b0001: begin
                                if (b.w1) begin
                                    b.s    = b.s | 4'b1001;
                                    b.cin  = 1'b1;
                                    b.abus = 1'b1;
                                    b.drw  = 1'b1;
                                    b.ldz  = 1'b1;
                                    b.ldc  = 1'b1;
                                end
                                if (b.w2) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b0010: begin
                                if (b.w1) begin
                                    b.s    = b.s | 4'b0110;
                                    b.abus = 1'b1;
                                    b.drw  = 1'b1;
                                    b.ldz  = 1'b1;
                                    b.ldc  = 1'b1;
                                end
                                if (b.w2) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b0011: begin
                                if (b.w1) begin
                                    b.m    = 1'b1;
                                    b.s    = b.s | 4'b1011;
                                    b.abus = 1'b1;
                                    b.drw  = 1'b1;
                                    b.ldz  = 1'b1;
                                end
                                if (b.w2) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b0100: begin
                                if (b.w1) begin
                                    b.abus = 1'b1;
                                    b.drw  = 1'b1;
                                    b.ldz  = 1'b1;
                                    b.ldc  = 1'b1;
                                end
                                if (b.w2) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b0101: begin
                                if (b.w1) begin
                                    b.m        = 1'b1;
                                    b.s        = b.s | 4'b1010;
                                    b.abus     = 1'b1;
                                    b.lar      = 1'b1;
                                    b.long_cyc = 1'b1;
                                end
                                if (b.w2) begin
                                    b.mbus = 1'b1;
                                    b.drw  = 1'b1;
                                end
                                if (b.w3) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b0110: begin
                                if (b.w1) begin
                                    b.m        = 1'b1;
                                    b.s        = b.s | 4'b1111;
                                    b.abus     = 1'b1;
                                    b.lar      = 1'b1;
                                    b.long_cyc = 1'b1;
                                end
                                if (b.w2) begin
                                    b.m    = 1'b1;
                                    b.s    = b.s | 4'b1010;
                                    b.abus = 1'b1;
                                    b.memw = 1'b1;
                                end
                                if (b.w3) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b0111, 4'b1000: begin
                                if (b.w1)
                                    b.pcadd = (b.ir == 4'b0111) ? b.c : b.z;
                                if (b.w2) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b1001: begin
                                if (b.w1) begin
                                    b.m    = 1'b1;
                                    b.s    = b.s | 4'b1111;
                                    b.abus = 1'b1;
                                    b.lpc  = 1'b1;
                                end
                                if (b.w2) begin
                                    b.lir   = 1'b1;
                                    b.pcinc = 1'b1;
                                end
                            end
                            4'b1110: begin
                                if (b.w1) begin
                                    b.stop      = 1'b1;
                                    b.short_cyc = 1'b1;
                                end
                            end
                            default: begin
                                if (b.w1) begin
                                    b.lir       = 1'b1;
                                    b.pcinc     = 1'b1;
                                    b.short_cyc = 1'b1;
                                end
                            end
                        endcase
                    end
                end

                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the TEC-8 control unit, checked every cycle
// against a beat-level behavioural model.
module tb_cpu;
    typedef struct packed {
        logic       drw, pcinc, lpc, lar;
        logic       pcadd, arinc, selctl, memw;
        logic       stop, lir, ldz, ldc, cin;
        logic [3:0] s;
        logic       m, abus, sbus, mbus;
        logic       shrt, lng;
        logic [3:0] sel;
    } o_t;

    logic t3;
    logic clr;
    logic run;
    logic m_st0;
    int   checks;
    int   failures;
    int   cyc;

    cpu_if b ();

    cpu dut (
        .t3  (t3),
        .clr (clr),
        .b   (b)
    );

    o_t act;
    assign act = {
        b.drw, b.pcinc, b.lpc, b.lar,
        b.pcadd, b.arinc, b.selctl, b.memw,
        b.stop, b.lir, b.ldz, b.ldc, b.cin,
        b.s, b.m, b.abus, b.sbus, b.mbus,
        b.short_cyc, b.long_cyc,
        b.sel3, b.sel2, b.sel1, b.sel0
    };

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    // Controls one beat asks for, in isolation
    function automatic o_t terms(
        input logic [2:0] md, input logic [3:0] op,
        input int bt, input logic st,
        input logic cc, input logic zz);
        o_t o;
        int fb;
        o = '0;
        case (md)
            3'b001, 3'b010: if (bt == 1) begin
                o.stop = 1; o.shrt = 1; o.selctl = 1;
                if (!st) begin
                    o.sbus = 1; o.lar = 1;
                end else if (md == 3'b001) begin
                    o.sbus = 1; o.memw = 1; o.arinc = 1;
                end else begin
                    o.mbus = 1; o.arinc = 1;
                end
            end
            3'b011: begin
                if (bt == 1) begin
                    o.sel = 4'b0001; o.selctl = 1; o.stop = 1;
                end
                if (bt == 2) begin
                    o.sel = 4'b1011; o.selctl = 1; o.stop = 1;
                end
            end
            3'b100: if (bt == 1 || bt == 2) begin
                o.sbus = 1; o.drw = 1;
                o.selctl = 1; o.stop = 1;
                o.sel[3:2] = 2'(2 * int'(st) + bt - 1);
                o.sel[1] = (bt == 1) ? !st : st;
                o.sel[0] = (bt == 1);
            end
            3'b000: if (!st) begin
                if (bt == 1) begin o.sbus = 1; o.lpc = 1; end
                if (bt == 2) begin o.lir = 1; o.pcinc = 1; end
            end else if (op == 4'd14) begin
                if (bt == 1) begin o.stop = 1; o.shrt = 1; end
            end else if (op == 4'd0 || op > 4'd9) begin
                if (bt == 1) begin
                    o.lir = 1; o.pcinc = 1; o.shrt = 1;
                end
            end else begin
                fb = (op == 5 || op == 6) ? 3 : 2;
                if (bt == fb) begin o.lir = 1; o.pcinc = 1; end
                if (bt == 1) case (op)
                    4'd1: begin
                        o.s = 4'b1001; o.cin = 1; o.abus = 1;
                        o.drw = 1; o.ldz = 1; o.ldc = 1;
                    end
                    4'd2: begin
                        o.s = 4'b0110; o.abus = 1;
                        o.drw = 1; o.ldz = 1; o.ldc = 1;
                    end
                    4'd3: begin
                        o.m = 1; o.s = 4'b1011; o.abus = 1;
                        o.drw = 1; o.ldz = 1;
                    end
                    4'd4: begin
                        o.abus = 1; o.drw = 1;
                        o.ldz = 1; o.ldc = 1;
                    end
                    4'd5: begin
                        o.m = 1; o.s = 4'b1010; o.abus = 1;
                        o.lar = 1; o.lng = 1;
                    end
                    4'd6: begin
                        o.m = 1; o.s = 4'b1111; o.abus = 1;
                        o.lar = 1; o.lng = 1;
                    end
                    4'd7: o.pcadd = cc;
                    4'd8: o.pcadd = zz;
                    4'd9: begin
                        o.m = 1; o.s = 4'b1111;
                        o.abus = 1; o.lpc = 1;
                    end
                    default: ;
                endcase
                if (bt == 2 && op == 5) begin
                    o.mbus = 1; o.drw = 1;
                end
                if (bt == 2 && op == 6) begin
                    o.m = 1; o.s = 4'b1010;
                    o.abus = 1; o.memw = 1;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic o_t model();
        o_t e;
        logic [2:0] md;
        logic [2:0] w;
        e  = '0;
        md = {b.swc, b.swb, b.swa};
        w  = {b.w3, b.w2, b.w1};
        if (!clr)
            for (int k = 1; k <= 3; k++)
                if (w[k-1])
                    e = o_t'(e | terms(md, b.ir, k, m_st0,
                                       b.c, b.z));
        return e;
    endfunction

    // The phase flag sets on the first qualifying beat of a mode
    always @(negedge t3 or posedge clr) begin
        if (clr)
            m_st0 = 1'b0;
        else if (!m_st0) begin
            case ({b.swc, b.swb, b.swa})
                3'b001, 3'b010: if (b.w1) m_st0 = 1'b1;
                3'b000, 3'b100: if (b.w2) m_st0 = 1'b1;
                default: ;
            endcase
        end
    end

    always @(posedge t3) begin
        #3;
        if (run) begin
            o_t e;
            e = model();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL cycle%0d outputs got=%h want=%h",
                         cyc, act, e);
            end
        end
    end

    task automatic pin(input string nm,
                       input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic step(input logic [2:0] md,
                        input logic [3:0] op,
                        input logic [2:0] w,
                        input logic cc = 1'b0,
                        input logic zz = 1'b0);
        @(posedge t3);
        cyc++;
        clr = 1'b0;
        {b.swc, b.swb, b.swa} = md;
        b.ir = op;
        {b.w3, b.w2, b.w1} = w;
        b.c = cc;
        b.z = zz;
        #4;
    endtask

    task automatic pulse_clr(input logic [2:0] md);
        @(posedge t3);
        cyc++;
        clr = 1'b1;
        {b.swc, b.swb, b.swa} = md;
        b.ir = 4'b0101;
        {b.w3, b.w2, b.w1} = 3'b001;
        b.c = 1'b1;
        b.z = 1'b1;
        #4;
        pin("clr_quiet", {3'b000, |act}, 4'b0000);
    endtask

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        run      = 1'b0;
        clr      = 1'b1;
        m_st0    = 1'b0;
        {b.swc, b.swb, b.swa} = 3'b000;
        b.ir = 4'b0000;
        {b.w3, b.w2, b.w1} = 3'b000;
        b.c = 1'b0;
        b.z = 1'b0;
        run = 1'b1;

        pulse_clr(3'b000);
        pulse_clr(3'b011);
        step(3'b000, 4'd0, W1);
        pin("run_w1_sbus_lpc", {2'b00, b.sbus, b.lpc}, 4'b0011);
        step(3'b000, 4'd0, W2);
        pin("run_w2_lir_pcinc", {2'b00, b.lir, b.pcinc}, 4'b0011);
        step(3'b000, 4'd1, W1);
        pin("add_s", b.s, 4'b1001);
        pin("add_cin_ldc", {2'b00, b.cin, b.ldc}, 4'b0011);
        step(3'b000, 4'd1, W2);
        step(3'b000, 4'd5, W1);
        pin("ld_s", b.s, 4'b1010);
        pin("ld_lar_long", {2'b00, b.lar, b.long_cyc}, 4'b0011);
        step(3'b000, 4'd5, W2);
        pin("ld_mbus_drw", {2'b00, b.mbus, b.drw}, 4'b0011);
        step(3'b000, 4'd5, W3);
        pin("ld_w3_fetch", {2'b00, b.lir, b.pcinc}, 4'b0011);
        step(3'b000, 4'd7, W1, 1'b0);
        pin("jc_c0", {3'b000, b.pcadd}, 4'b0000);
        step(3'b000, 4'd7, W1, 1'b1);
        pin("jc_c1", {3'b000, b.pcadd}, 4'b0001);
        step(3'b000, 4'd8, W1, 1'b1, 1'b0);
        step(3'b000, 4'd8, W1, 1'b0, 1'b1);
        step(3'b000, 4'd8, W2);
        for (int op = 2; op <= 4; op++) begin
            step(3'b000, 4'(op), W1);
            step(3'b000, 4'(op), W2);
        end
        step(3'b000, 4'd6, W1);
        step(3'b000, 4'd6, W2);
        pin("st_w2_s", b.s, 4'b1010);
        step(3'b000, 4'd6, W3);
        step(3'b000, 4'd9, W1);
        step(3'b000, 4'd9, W2);
        step(3'b000, 4'd14, W1);
        pin("stp_stop_short", {2'b00, b.stop, b.short_cyc}, 4'b0011);
        step(3'b000, 4'd14, W2);
        step(3'b000, 4'd0, W1);
        step(3'b000, 4'd12, W1);
        step(3'b000, 4'd15, W2);
        step(3'b000, 4'd1, W1 | W2);
        step(3'b000, 4'd6, W1 | W2 | W3);

        pulse_clr(3'b000);
        step(3'b000, 4'd1, W1);
        pin("rerun_lpc", {3'b000, b.lpc}, 4'b0001);

        pulse_clr(3'b100);
        step(3'b100, 4'd0, W1);
        pin("wreg_r0", {b.sel3, b.sel2, b.sel1, b.sel0}, 4'b0011);
        step(3'b100, 4'd0, W2);
        pin("wreg_r1", {b.sel3, b.sel2, b.sel1, b.sel0}, 4'b0100);
        step(3'b100, 4'd0, W1);
        pin("wreg_r2", {b.sel3, b.sel2, b.sel1, b.sel0}, 4'b1001);
        step(3'b100, 4'd0, W2);
        pin("wreg_r3", {b.sel3, b.sel2, b.sel1, b.sel0}, 4'b1110);
        pin("wreg_drw_sbus", {2'b00, b.drw, b.sbus}, 4'b0011);
        step(3'b100, 4'd0, W3);

        pulse_clr(3'b001);
        step(3'b001, 4'd0, W1);
        pin("wmem_first", {b.lar, b.sbus, b.stop, b.short_cyc},
            4'b1111);
        step(3'b001, 4'd0, W1);
        pin("wmem_next", {b.lar, b.memw, b.arinc, b.sbus}, 4'b0111);
        step(3'b001, 4'd0, W1);
        step(3'b001, 4'd0, W2);

        pulse_clr(3'b010);
        step(3'b010, 4'd0, W1);
        pin("rmem_first", {2'b00, b.lar, b.sbus}, 4'b0011);
        step(3'b010, 4'd0, W1);
        pin("rmem_next", {b.lar, b.sbus, b.mbus, b.arinc}, 4'b0011);

        pulse_clr(3'b011);
        step(3'b011, 4'd0, W1);
        step(3'b011, 4'd0, W2);
        pin("rreg_w2", {b.sel3, b.sel2, b.sel1, b.sel0}, 4'b1011);
        step(3'b011, 4'd0, W1);

        pulse_clr(3'b101);
        step(3'b101, 4'd1, W1);
        step(3'b111, 4'd1, W2);

        @(posedge t3);
        run = 1'b0;
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
